// File: rtl/awake_bpm_pkg.sv
// Shared constants, window FSM encoding and channel helpers for the BPM acquisition path.
package awake_bpm_pkg;

  localparam int unsigned ADC_BIT_WIDTH = 16;
  localparam int unsigned NUM_CH        = 4;
  localparam int unsigned DATA_WIDTH    = NUM_CH * ADC_BIT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_WINDOW = 2'd2,
    ST_GAP    = 2'd3
  } win_state_e;

  function automatic logic [ADC_BIT_WIDTH-1:0] ch_slice(
    input logic [DATA_WIDTH-1:0] data,
    input int unsigned           ch
  );
    return data[ch*ADC_BIT_WIDTH +: ADC_BIT_WIDTH];
  endfunction

endpackage

// File: rtl/adc_fmt_conv.sv
// One ADC channel: registered offset-binary to two's-complement conversion (or plain register).
module adc_fmt_conv
  import awake_bpm_pkg::*;
#(
  parameter int unsigned W             = ADC_BIT_WIDTH,
  parameter bit          OFFSET_BINARY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] dout_r;

  // Converted sample register, updated every clock regardless of framing.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r <= '0;
    end else if (OFFSET_BINARY) begin
      dout_r <= {~din[W-1], din[W-2:0]};
    end else begin
      dout_r <= din;
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/adc_window_gen.sv
// Trigger-gated acquisition window generator: delay, framed window of LENGTH words, forced idle gap.
module adc_window_gen
  import awake_bpm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned MIN_GAP       = 4,
  parameter bit          OFFSET_BINARY = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic                  trig,
  input  logic                  arm,
  input  logic [CNT_WIDTH-1:0]  delay_cfg,
  input  logic [CNT_WIDTH-1:0]  length_cfg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  busy,
  output logic                  window_done,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  trig_missed_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] GAP_LAST = CNT_WIDTH'(MIN_GAP);

  win_state_e             state_r;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic [CNT_WIDTH-1:0]   dly_r;
  logic [CNT_WIDTH-1:0]   len_r;
  logic [CNT_WIDTH-1:0]   frame_cnt_r;
  logic [CNT_WIDTH-1:0]   trig_missed_r;
  logic                   trig_d_r;
  logic                   dout_valid_r;
  logic                   busy_r;
  logic                   window_done_r;
  logic                   trig_edge_s;
  logic [DATA_WIDTH-1:0]  dout_s;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_conv
    adc_fmt_conv #(
      .W             (ADC_BIT_WIDTH),
      .OFFSET_BINARY (OFFSET_BINARY)
    ) u_conv (
      .clk  (clk),
      .rst  (rst),
      .din  (ch_slice(adc_data, ch)),
      .dout (dout_s[ch*ADC_BIT_WIDTH +: ADC_BIT_WIDTH])
    );
  end

  // Trigger history for rising-edge detection; tracks trig even while disarmed.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_d_r <= 1'b0;
    end else begin
      trig_d_r <= trig;
    end
  end

  assign trig_edge_s = arm & trig & ~trig_d_r;

  // Window FSM with registered framing, status and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      dly_r         <= CNT_ZERO;
      len_r         <= CNT_ZERO;
      frame_cnt_r   <= CNT_ZERO;
      trig_missed_r <= CNT_ZERO;
      dout_valid_r  <= 1'b0;
      busy_r        <= 1'b0;
      window_done_r <= 1'b0;
    end else begin
      dout_valid_r  <= 1'b0;
      window_done_r <= 1'b0;
      // Any armed edge outside IDLE is lost, including the one on the GAP exit cycle.
      if (trig_edge_s && (state_r != ST_IDLE) && (trig_missed_r != CNT_MAX)) begin
        trig_missed_r <= trig_missed_r + CNT_ONE;
      end else begin
        trig_missed_r <= trig_missed_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (trig_edge_s) begin
            dly_r  <= delay_cfg;
            len_r  <= length_cfg;
            cnt_r  <= CNT_ZERO;
            busy_r <= 1'b1;
            if (length_cfg == CNT_ZERO) begin
              state_r       <= ST_GAP;
              window_done_r <= 1'b1;
              frame_cnt_r   <= frame_cnt_r + CNT_ONE;
            end else if (delay_cfg == CNT_ZERO) begin
              state_r <= ST_WINDOW;
            end else begin
              state_r <= ST_DELAY;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_DELAY: begin
          if (cnt_r == dly_r - CNT_ONE) begin
            cnt_r   <= CNT_ZERO;
            state_r <= ST_WINDOW;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WINDOW: begin
          dout_valid_r <= 1'b1;
          if (cnt_r == len_r - CNT_ONE) begin
            window_done_r <= 1'b1;
            frame_cnt_r   <= frame_cnt_r + CNT_ONE;
            cnt_r         <= CNT_ZERO;
            state_r       <= ST_GAP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_GAP: begin
          // GAP_LAST+1 cycles here: the last window word is shown, then MIN_GAP low cycles.
          if (cnt_r == GAP_LAST) begin
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          cnt_r   <= CNT_ZERO;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign dout            = dout_s;
  assign dout_valid      = dout_valid_r;
  assign busy            = busy_r;
  assign window_done     = window_done_r;
  assign frame_cnt       = frame_cnt_r;
  assign trig_missed_cnt = trig_missed_r;

endmodule

// File: tb/tb_adc_window_gen.sv
// Scoreboard bench for adc_window_gen: directed triggers, expected words queued at trigger time.
module tb_adc_window_gen;
  import awake_bpm_pkg::*;

  localparam int MIN_GAP = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [DATA_WIDTH-1:0] adc_data;
  logic                  trig;
  logic                  arm;
  logic [15:0]           delay_cfg;
  logic [15:0]           length_cfg;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  busy;
  logic                  window_done;
  logic [15:0]           frame_cnt;
  logic [15:0]           trig_missed_cnt;

  adc_window_gen #(.CNT_WIDTH(16), .MIN_GAP(MIN_GAP), .OFFSET_BINARY(1'b1)) dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .trig(trig), .arm(arm),
    .delay_cfg(delay_cfg), .length_cfg(length_cfg), .dout(dout), .dout_valid(dout_valid),
    .busy(busy), .window_done(window_done), .frame_cnt(frame_cnt),
    .trig_missed_cnt(trig_missed_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    bit          last;
    bit          skip;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   edge_n = 0;
  int   exp_frames = 0;
  int   exp_missed = 0;

  logic [15:0] ch0_in  [0:2] = '{16'h8000, 16'h0000, 16'hFFFF};
  logic [15:0] ch0_out [0:2] = '{16'h0000, 16'h8000, 16'h7FFF};

  // ADC sample presented for clock edge n (edges counted from 1).
  function automatic logic [63:0] pattern(input int n);
    logic [15:0] c1, c2, c3;
    c1 = 16'(n * 3);
    c2 = 16'(16'h1234 + n);
    c3 = 16'(16'hF000 ^ n);
    return {c3, c2, c1, ch0_in[n % 3]};
  endfunction

  function automatic logic [63:0] expect_word(input int n);
    logic [63:0] p;
    p = pattern(n);
    return {p[63:48] ^ 16'h8000, p[47:32] ^ 16'h8000, p[31:16] ^ 16'h8000, ch0_out[n % 3]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) adc_data = pattern(edge_n + 1);

  // Monitor: every valid word or done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (dout_valid || window_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {62'd0, dout_valid, window_done}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.skip) begin
          chk("skip_valid", {63'd0, dout_valid}, 64'd0);
          chk("skip_done", {63'd0, window_done}, 64'd1);
        end else begin
          chk("word_valid", {63'd0, dout_valid}, 64'd1);
          chk("word_data", dout, mon_e.data);
          chk("word_done", {63'd0, window_done}, {63'd0, mon_e.last});
        end
      end
    end
  end

  // Raise trig at a negedge so edge k=edge_n+1 sees it; queue the window; return at negedge after k.
  task automatic fire(input int d, input int l, input int hold);
    int k;
    exp_t e;
    delay_cfg  = 16'(d);
    length_cfg = 16'(l);
    trig = 1'b1;
    k = edge_n + 1;
    if (l == 0) begin
      e.data = 64'd0; e.last = 1'b1; e.skip = 1'b1;
      exp_q.push_back(e);
    end else begin
      for (int i = 0; i < l; i++) begin
        e.data = expect_word(k + 1 + d + i);
        e.last = (i == l - 1);
        e.skip = 1'b0;
        exp_q.push_back(e);
      end
    end
    repeat (hold) @(negedge clk);
    trig = 1'b0;
    delay_cfg  = 16'd0;
    length_cfg = 16'd1;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", {63'd0, (n >= maxc)}, 64'd0);
    @(negedge clk);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_frame_cnt"}, {48'd0, frame_cnt}, 64'(exp_frames));
    chk({tag, "_missed_cnt"}, {48'd0, trig_missed_cnt}, 64'(exp_missed));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; trig = 1'b0; arm = 1'b0;
    delay_cfg = 16'd0; length_cfg = 16'd0;
    adc_data = pattern(1);
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 64'd0);
    chk("rst_valid", {63'd0, dout_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, window_done}, 64'd0);
    chk_counters("rst");
    rst = 1'b0;
    arm = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_dout", dout, expect_word(edge_n));

    // Test 1: D=3, L=5 exact framing and gap.
    fire(3, 5, 1);
    for (int j = 0; j <= 14; j++) begin
      if (j > 0) @(negedge clk);
      chk($sformatf("t1_valid_j%0d", j), {63'd0, dout_valid}, {63'd0, (j >= 4 && j <= 8)});
      chk($sformatf("t1_done_j%0d", j), {63'd0, window_done}, {63'd0, (j == 8)});
      chk($sformatf("t1_busy_j%0d", j), {63'd0, busy}, {63'd0, (j <= 8 + MIN_GAP)});
    end
    exp_frames++;
    wait_idle(100);
    chk_counters("t1");

    // Test 3: edges during WINDOW and GAP are missed, then a fresh window.
    fire(1, 6, 1);
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      trig = (j == 3 || j == 9);
    end
    trig = 1'b0;
    exp_frames++;
    exp_missed += 2;
    wait_idle(100);
    chk_counters("t3_missed");
    fire(0, 2, 1);
    exp_frames++;
    wait_idle(100);
    chk_counters("t3_new");

    // Edge on the GAP exit cycle is missed.
    fire(0, 2, 1);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      trig = (j == 6);
    end
    exp_frames++;
    exp_missed++;
    wait_idle(100);
    chk_counters("gap_exit");

    // First IDLE cycle accepts a new edge.
    fire(0, 2, 1);
    for (int j = 1; j <= 7; j++) @(negedge clk);
    fire(0, 1, 1);
    exp_frames += 2;
    wait_idle(100);
    chk_counters("first_idle");

    // Test 4: L=0 skip window.
    fire(0, 0, 1);
    for (int j = 0; j <= MIN_GAP + 2; j++) begin
      if (j > 0) @(negedge clk);
      chk($sformatf("t4_valid_j%0d", j), {63'd0, dout_valid}, 64'd0);
      chk($sformatf("t4_done_j%0d", j), {63'd0, window_done}, {63'd0, (j == 0)});
      chk($sformatf("t4_busy_j%0d", j), {63'd0, busy}, {63'd0, (j <= MIN_GAP)});
    end
    exp_frames++;
    wait_idle(100);
    chk_counters("t4");

    // Test 5: disarmed toggling, held trigger, arm dropped mid-window.
    arm = 1'b0;
    repeat (10) begin
      trig = 1'b1; @(negedge clk);
      trig = 1'b0; @(negedge clk);
    end
    chk("t5_busy_disarmed", {63'd0, busy}, 64'd0);
    chk_counters("t5_disarmed");
    arm = 1'b1;
    fire(2, 3, 30);
    exp_frames++;
    wait_idle(100);
    chk_counters("t5_held");
    fire(2, 3, 1);
    arm = 1'b0;
    exp_frames++;
    wait_idle(100);
    arm = 1'b1;
    chk_counters("t5_arm_drop");

    // Test 6: reset on window cycle 2 of L=8.
    fire(0, 8, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_valid", {63'd0, dout_valid}, 64'd0);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    chk("t6_done", {63'd0, window_done}, 64'd0);
    chk("t6_dout", dout, 64'd0);
    chk("t6_words_seen", 64'(exp_q.size()), 64'd6);
    exp_q.delete();
    exp_frames = 0;
    exp_missed = 0;
    chk_counters("t6_rst");
    rst = 1'b0;
    @(negedge clk);
    fire(1, 2, 1);
    exp_frames++;
    wait_idle(100);
    chk_counters("t6_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
